mips_control_fsm: RTL and testbench
===================================

# mips_control_fsm

Multi-cycle main controller for the MIPS datapath; the initiator side of the ALU's `control_bus`/`funct` interface. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives every datapath mux, write-enable and the 2-bit ALU operation code from the current opcode. Waits on a memory ready handshake and reports completed and illegal instructions.

## Interface

Parameters:
- none

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: `instr[31:26]` from the instruction register; sampled only in DECODE.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if the ALU `zero` output is 1.
- `pc_source` out 2: 00 is the ALU result, 01 is ALUOut, 10 is the jump target.
- `i_or_d` out 1: 0 selects PC as the memory address; 1 selects ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: load the instruction register.
- `mem_to_reg` out 1: register write data; 0 is ALUOut, 1 is MDR.
- `reg_dst` out 1: write register; 0 is rt, 1 is rd.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: 0 is PC, 1 is register A.
- `alu_src_b` out 2: 00 is B, 01 is constant 4, 10 is sign-extended immediate, 11 is sign-extended immediate << 2.
- `alu_op` out 2: 00 is add, 01 is subtract, 10 is decode by funct.
- `instr_done` out 1: one-cycle pulse in the last state of each instruction.
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation

- State register is 4 bits. Outputs are decoded from the state; the only inputs that qualify outputs are `mem_ready` and `opcode`, as listed below.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08 (addi only when configured).
- In each state, any output not listed here is 0.
- FETCH: `mem_read=1`, `i_or_d=0`, `alu_src_a=0`, `alu_src_b=01`, `alu_op=00`, `pc_source=00`.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Goes to DECODE when `mem_ready=1`; otherwise stays in FETCH.
- DECODE: `alu_src_a=0`, `alu_src_b=11`, `alu_op=00`.
  - Next state by opcode: lw/sw go to MEM_ADDR, R-type to EXECUTE, beq to BRANCH, j to JUMP, addi to ADDI_EXEC.
  - Any other opcode goes to FETCH with `illegal_op=1` for that cycle.
- MEM_ADDR: `alu_src_a=1`, `alu_src_b=10`, `alu_op=00`. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read=1`, `i_or_d=1`. Goes to MEM_WB when `mem_ready=1`; otherwise holds.
- MEM_WB: `reg_write=1`, `mem_to_reg=1`, `reg_dst=0`, `instr_done=1`. Goes to FETCH.
- MEM_WRITE: `mem_write=1`, `i_or_d=1`.
  - `instr_done` equals `mem_ready`.
  - Goes to FETCH when `mem_ready=1`; otherwise holds.
- EXECUTE: `alu_src_a=1`, `alu_src_b=00`, `alu_op=10`. Goes to ALU_WB.
- ALU_WB: `reg_write=1`, `reg_dst=1`, `mem_to_reg=0`, `instr_done=1`. Goes to FETCH.
- BRANCH: `alu_src_a=1`, `alu_src_b=00`, `alu_op=01`, `pc_write_cond=1`, `pc_source=01`, `instr_done=1`. Goes to FETCH.
- JUMP: `pc_write=1`, `pc_source=10`, `instr_done=1`. Goes to FETCH.
- The `opcode` input is used only in DECODE and MEM_ADDR. The instruction register is loaded only in FETCH, so `opcode` is stable in both states.

## Timing

- Reset:
  - `reset=1` at a rising edge forces the state to FETCH, overriding every other input, including a reset arriving mid-instruction or mid-wait.
  - Outputs are valid combinationally from the state, so after reset they take the FETCH values: `mem_read=1`, `alu_src_b=01`, and all else 0 while `mem_ready=0`.
- Cycles per instruction, with zero-wait memory (`mem_ready` always 1):
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
- Memory waits: each cycle with `mem_ready=0` in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- While waiting, the request signals stay asserted and the address-select signals are held stable.
- `mem_ready` outside FETCH, MEM_READ and MEM_WRITE is ignored.
- Illegal opcode: 2 cycles (FETCH, DECODE), then the next fetch proceeds; no register or memory side effects.

## Configuration

- `MIPS_ADDI_EN`, when defined:
  - opcode 0x08 goes to ADDI_EXEC (`alu_src_a=1`, `alu_src_b=10`, `alu_op=00`);
  - then to ADDI_WB (`reg_write=1`, `reg_dst=0`, `mem_to_reg=0`, `instr_done=1`);
  - then to FETCH.
- When undefined: states 10 and 11 are unreachable and 0x08 is treated as illegal (`illegal_op` pulse).
- If the state register ever holds 10–15 without the feature, it recovers to FETCH on the next edge.

## Structure

- Shared package `mips_pkg`:
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`);
  - ALU op codes (`ALUOP_ADD=2'b00`, `ALUOP_SUB=2'b01`, `ALUOP_FUNCT=2'b10`);
  - the state enumeration;
  - the `alu_src_b` and `pc_source` select constants.
- No sub-module: a single FSM with a next-state process and an output decode process.

## Test plan

- Reset with `mem_ready=1`, then opcode 0x00 → `state` sequence 0,1,6,7,0; `alu_op=10` in EXECUTE; `reg_write=1`, `reg_dst=1` in ALU_WB; `instr_done` pulses in cycle 4.
- lw (0x23) with `mem_ready` low for 2 cycles in MEM_READ → sequence 0,1,2,3,3,3,4,0; `i_or_d=1` held through the wait; `mem_to_reg=1` in MEM_WB.
- sw (0x2B) → `mem_write=1` only in MEM_WRITE; `reg_write` is never asserted; 4 cycles total.
- beq (0x04) → BRANCH shows `alu_op=01`, `pc_write_cond=1`, `pc_source=01`; j (0x02) → JUMP shows `pc_write=1`, `pc_source=10`.
- Opcode 0x3F → `illegal_op` pulse in DECODE; returns to FETCH; no write enables asserted.
- `reset` asserted in MEM_READ during a wait → FETCH on the next edge. Opcode 0x08 → states 10,11 when `MIPS_ADDI_EN` is defined, `illegal_op` pulse when it is not.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, ALU op codes,
// datapath select constants and the controller state enumeration.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

endpackage

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS main controller: fetch/decode/execute/memory/write-back sequencing.
// Define MIPS_ADDI_EN to add the addi path (states 10/11); otherwise 0x08 is illegal.
module mips_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
`ifdef MIPS_ADDI_EN
          OP_ADDI:      state_d = StAddiExec;
`endif
          default:      state_d = StFetch;
        endcase
      end
      StMemAddr:  state_d = (opcode == OP_LW) ? StMemRead : StMemWrite;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StExecute:  state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
`ifdef MIPS_ADDI_EN
      StAddiExec: state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
`endif
      // Unused encodings fall back to fetch on the next edge.
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PC_SRC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_SRC_B_REG;
    alu_op        = ALUOP_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = ALU_SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = ALU_SRC_B_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal_op = 1'b0;
`ifdef MIPS_ADDI_EN
          OP_ADDI:                              illegal_op = 1'b0;
`endif
          default:                              illegal_op = 1'b1;
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_SRC_B_IMM;
      end
      StMemRead: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      StMemWrite: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      StAluWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        instr_done    = 1'b1;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        instr_done = 1'b1;
      end
`ifdef MIPS_ADDI_EN
      StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_SRC_B_IMM;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Randomized self-checking bench for mips_control_fsm: per-instruction state paths and
// per-state control words from a table model, plus reset overrides. Honors MIPS_ADDI_EN.
module tb_mips_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int st;
    bit rdy;
  } step_t;

  step_t steps[$];

  mips_control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .instr_done   (instr_done),
    .illegal_op   (illegal_op),
    .state        (state)
  );

  always #5 clk = ~clk;

  logic [17:0] ctl;
  assign ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, instr_done,
                illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
`ifdef MIPS_ADDI_EN
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
`else
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02};
`endif
  endfunction

  // Control word each state must present, straight from the state table.
  function automatic logic [17:0] exp_ctl(input int st, input bit rdy, input logic [5:0] op);
    logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0;
    logic sa = 0, dn = 0, ill = 0;
    logic [1:0] ps = 0, sb = 0, ao = 0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      1:  begin sb = 2'b11; ill = !legal(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; iod = 1; dn = rdy; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
      9:  begin pw = 1; ps = 2'b10; dn = 1; end
      10: begin sa = 1; sb = 2'b10; end
      11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, ps, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, dn, ill};
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected state path of one instruction, with wf fetch waits and wm memory waits.
  task automatic build_path(input logic [5:0] op, input int wf, input int wm);
    steps.delete();
    for (int i = 0; i < wf; i++) steps.push_back('{0, 1'b0});
    steps.push_back('{0, 1'b1});
    steps.push_back('{1, rnd()});
    case (op)
      6'h00: begin steps.push_back('{6, rnd()}); steps.push_back('{7, rnd()}); end
      6'h23: begin
        steps.push_back('{2, rnd()});
        for (int i = 0; i < wm; i++) steps.push_back('{3, 1'b0});
        steps.push_back('{3, 1'b1});
        steps.push_back('{4, rnd()});
      end
      6'h2B: begin
        steps.push_back('{2, rnd()});
        for (int i = 0; i < wm; i++) steps.push_back('{5, 1'b0});
        steps.push_back('{5, 1'b1});
      end
      6'h04: steps.push_back('{8, rnd()});
      6'h02: steps.push_back('{9, rnd()});
`ifdef MIPS_ADDI_EN
      6'h08: begin steps.push_back('{10, rnd()}); steps.push_back('{11, rnd()}); end
`endif
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    build_path(op, wf, wm);
    foreach (steps[i]) begin
      @(negedge clk);
      opcode    = op;
      mem_ready = steps[i].rdy;
      #1;
      check($sformatf("state op%02h step%0d", op, i), 32'(state), 32'(steps[i].st));
      check($sformatf("ctl op%02h st%0d", op, steps[i].st), 32'(ctl),
            32'(exp_ctl(steps[i].st, steps[i].rdy, op)));
    end
  endtask

  logic [5:0] op_list[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h00};

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset ctl", 32'(ctl), 32'(exp_ctl(0, 1'b0, 6'h00)));
    reset = 1'b0;

    // Directed pass over every opcode with zero-wait memory, then lw with two read waits.
    for (int i = 0; i < 7; i++) run_instr(op_list[i], 0, 0);
    run_instr(6'h23, 0, 2);

    // Reset during a MEM_READ wait.
    run_instr(6'h23, 0, 0);
    build_path(6'h23, 0, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = steps[i].rdy;
      #1;
      check("pre-reset path", 32'(state), 32'(steps[i].st));
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset     = 1'b1;
    #1;
    check("wait before reset edge", 32'(state), 32'd3);
    @(negedge clk);
    #1;
    check("reset from mem_read", 32'(state), 32'd0);
    // Reset overrides a ready fetch.
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("reset beats mem_ready", 32'(state), 32'd0);
    reset     = 1'b0;
    mem_ready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : op_list[$urandom_range(0, 6)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "timeout");
  end

endmodule
